conv_bn_relu_stream: RTL and testbench
======================================

Name: conv_bn_relu_stream

Overview:
- Per-channel batch-norm plus ReLU stage that sits directly downstream of a 1x1 convolution block's aligned output.
- Input is the convolution's channel-interleaved pixel stream: for each pixel, channels 0..CHANNEL_NUM-1 arrive in order.
- Each word becomes y = relu(sat(round(x*scale[c] >> FRAC_BITS) + bias[c])).
- Per-channel scale/bias are loaded serially through a parameter port, in the same style as the convolution weight load.

Parameters:
- DATA_WIDTH, 16, width of pixel, scale and bias words; signed two's complement.
- FRAC_BITS, 8, fractional bits of pixel, scale and bias (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- CHANNEL_NUM, 128, number of channels per pixel; equals the upstream CHANNEL_NUM_OUT.
- IMAGE_SIZE, 1024, pixels per frame (width*height at this stage's resolution).

Ports:
- clk, input, 1, sole clock; rising edge.
- reset, input, 1, asynchronous active-low reset.
- valid_param_in, input, 1, parameter word strobe.
- param_in, input, DATA_WIDTH, parameter word: scale[0], bias[0], scale[1], bias[1], ... (2*CHANNEL_NUM words).
- valid_in, input, 1, pixel word strobe.
- pxl_in, input, DATA_WIDTH, pixel word.
- pxl_out, output, DATA_WIDTH, normalised and rectified word.
- valid_out, output, 1, pxl_out strobe.
- ch_out, output, clog2(CHANNEL_NUM), channel index of pxl_out.
- params_ready, output, 1, high in RUN state.
- frame_done, output, 1, one-cycle pulse with the last output word of a frame.
- err, output, 1, sticky protocol error flag; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous): state=LOAD, all counters 0, pipeline valids 0.
- Outputs at reset: pxl_out=0, valid_out=0, ch_out=0, params_ready=0, frame_done=0, err=0. The parameter RAM is not cleared.
- No backpressure: the block accepts one word per cycle on either strobe, and strobes may be asserted on consecutive cycles.

State LOAD:
- Each valid_param_in writes param_in to slot param_cnt; param_cnt then increments.
- Even slots hold scale, odd slots hold bias.
- When slot 2*CHANNEL_NUM-1 is written, param_cnt returns to 0 and state goes to RUN on the next cycle.
- valid_in in LOAD: word dropped, err set.

State RUN:
- Each valid_in word is tagged with ch_cnt; ch_cnt wraps CHANNEL_NUM-1 -> 0 and increments pix_cnt at the wrap.
- pix_cnt wraps IMAGE_SIZE-1 -> 0. The word with ch_cnt=CHANNEL_NUM-1 and pix_cnt=IMAGE_SIZE-1 carries a last tag.
- valid_param_in at a frame boundary (ch_cnt=0, pix_cnt=0, pipeline empty): state goes to LOAD and that word is written to slot 0. Reload is legal.
- valid_param_in at any other time in RUN: ignored, err set.
- valid_param_in and valid_in in the same cycle at a boundary: the parameter word wins, the pixel is dropped, err set.

Pipeline (3 stages; latency 3 cycles from valid_in to valid_out):
- S1: read scale/bias for ch_cnt; compute p = pxl_in*scale as a signed 2*DATA_WIDTH product.
- S2: q = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS, an arithmetic shift (round half up); s = q + sign-extended bias, computed at 2*DATA_WIDTH+1 bits.
- S3: saturate s to [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1], then relu (negative -> 0). Register pxl_out, ch_out, valid_out, and frame_done = valid & last.
- When valid_out=0, pxl_out and ch_out hold their previous values.

Reset mid-frame:
- Pipeline flushed; state returns to LOAD.
- Parameters must be reloaded before RUN resumes. The RAM contents survive, but params_ready stays 0 until a full load completes.

Test Plan:
- Load CHANNEL_NUM=4 with scale=0x0100 and bias=0x0080 for every channel; send pxl_in=0x0200 on ch0 -> pxl_out=0x0280, ch_out=0, valid_out exactly 3 cycles after valid_in; params_ready rises the cycle after the 8th parameter word.
- Same parameters, bias=0; send pxl_in=0xFE00 -> pxl_out=0x0000 with valid_out=1 (ReLU clamp).
- scale=0x0200, bias=0x0000; send pxl_in=0x7F00 -> pxl_out=0x7FFF (positive saturation); send pxl_in=0x8000 -> 0x0000.
- scale=0x0080, bias=0; send pxl_in=0x0001 -> pxl_out=0x0001 (round half up); send pxl_in=0x0002 -> 0x0001.
- IMAGE_SIZE=2, CHANNEL_NUM=4: send 8 back-to-back words -> ch_out sequence 0,1,2,3,0,1,2,3 and frame_done high only with the 8th output. Then reload parameters with new per-channel biases and send a second frame -> new biases applied, err=0.
- Protocol errors:
  - valid_in during LOAD -> no valid_out, err=1.
  - valid_param_in while pix_cnt=1 in RUN -> ignored, err=1.
  - reset=0 asserted for 1 cycle mid-frame -> all outputs 0 immediately (asynchronous), params_ready=0, err=0.

Source files
------------

// File: rtl/conv_bn_relu_stream_if.sv
// conv_bn_relu_stream_if: parameter-load, pixel-in and result-out signals of the BN+ReLU stage
interface conv_bn_relu_stream_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNEL_NUM = 128
);
  localparam int CW = CHANNEL_NUM > 1 ? $clog2(CHANNEL_NUM) : 1;
  logic                  valid_param_in;
  logic [DATA_WIDTH-1:0] param_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic [CW-1:0]         ch_out;
  logic                  params_ready;
  logic                  frame_done;
  logic                  err;
  modport master (
    output valid_param_in, param_in, valid_in, pxl_in,
    input  pxl_out, valid_out, ch_out, params_ready, frame_done, err
  );
  modport slave (
    input  valid_param_in, param_in, valid_in, pxl_in,
    output pxl_out, valid_out, ch_out, params_ready, frame_done, err
  );
endinterface

// File: rtl/conv_bn_relu_stream.sv
// conv_bn_relu_stream: per-channel batch-norm scale/bias plus ReLU on a channel-interleaved stream
module conv_bn_relu_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int CHANNEL_NUM = 128,
  parameter int IMAGE_SIZE  = 1024
) (
  input logic clk,
  input logic reset,
  conv_bn_relu_stream_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = 2 * DW + 1;
  localparam int CW = CHANNEL_NUM > 1 ? $clog2(CHANNEL_NUM) : 1;
  localparam int PW = $clog2(2 * CHANNEL_NUM);
  localparam int XW = IMAGE_SIZE > 1 ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DW - 1) - 1);
  logic [0:0]             r_state;
  logic [PW-1:0]          r_param_cnt;
  logic [CW-1:0]          r_ch_cnt;
  logic [XW-1:0]          r_pix_cnt;
  logic signed [DW-1:0]   r_scale [CHANNEL_NUM];
  logic signed [DW-1:0]   r_bias  [CHANNEL_NUM];
  logic signed [2*DW-1:0] r_p;
  logic signed [DW-1:0]   r_b1;
  logic signed [SW-1:0]   r_s;
  logic [CW-1:0]          r_c1, r_c2, r_ch_out;
  logic                   r_v1, r_v2, r_l1, r_l2;
  logic [DW-1:0]          r_pxl_out;
  logic                   r_valid_out, r_frame_done, r_err;
  logic                   w_load, w_boundary, w_pwr, w_pix, w_bad, w_full, w_last_ch, w_last_px;
  logic [PW-1:0]          w_slot;
  logic signed [SW-1:0]   w_q;
  logic [DW-1:0]          w_sat;
  // A reload may only start once the previous frame has fully left S1/S2
  assign w_load     = r_state == LOAD;
  assign w_boundary = r_ch_cnt == '0 && r_pix_cnt == '0 && !r_v1 && !r_v2;
  assign w_pwr      = bus.valid_param_in && (w_load || w_boundary);
  assign w_slot     = w_load ? r_param_cnt : '0;
  assign w_full     = w_slot == PW'(2 * CHANNEL_NUM - 1);
  assign w_pix      = bus.valid_in && !w_load && !(bus.valid_param_in && w_boundary);
  assign w_bad      = (bus.valid_in && !w_pix) || (bus.valid_param_in && !w_pwr);
  assign w_last_ch  = r_ch_cnt == CW'(CHANNEL_NUM - 1);
  assign w_last_px  = r_pix_cnt == XW'(IMAGE_SIZE - 1);
  assign w_q        = (SW'(r_p) + HALF) >>> FRAC_BITS;
  assign w_sat      = r_s[SW-1] ? '0 : r_s > MAXV ? MAXV[DW-1:0] : r_s[DW-1:0];
  always_ff @(posedge clk)
    if (w_pwr) begin
      if (w_slot[0]) r_bias[w_slot[PW-1:1]] <= bus.param_in;
      else           r_scale[w_slot[PW-1:1]] <= bus.param_in;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state      <= LOAD;
      r_param_cnt  <= '0;
      r_ch_cnt     <= '0;
      r_pix_cnt    <= '0;
      r_p          <= '0;
      r_b1         <= '0;
      r_s          <= '0;
      r_c1         <= '0;
      r_c2         <= '0;
      r_l1         <= 1'b0;
      r_l2         <= 1'b0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_pxl_out    <= '0;
      r_ch_out     <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= r_err | w_bad;
      if (w_pwr) begin
        r_state     <= w_full ? RUN : LOAD;
        r_param_cnt <= w_full ? '0 : w_slot + 1'b1;
      end
      if (w_pix) begin
        r_ch_cnt <= w_last_ch ? '0 : r_ch_cnt + 1'b1;
        if (w_last_ch) r_pix_cnt <= w_last_px ? '0 : r_pix_cnt + 1'b1;
        r_p  <= $signed(bus.pxl_in) * r_scale[r_ch_cnt];
        r_b1 <= r_bias[r_ch_cnt];
        r_c1 <= r_ch_cnt;
        r_l1 <= w_last_ch && w_last_px;
      end
      r_v1 <= w_pix;
      if (r_v1) begin
        r_s  <= w_q + SW'(r_b1);
        r_c2 <= r_c1;
        r_l2 <= r_l1;
      end
      r_v2 <= r_v1;
      if (r_v2) begin
        r_pxl_out <= w_sat;
        r_ch_out  <= r_c2;
      end
      r_valid_out  <= r_v2;
      r_frame_done <= r_v2 && r_l2;
    end
  assign bus.pxl_out      = r_pxl_out;
  assign bus.ch_out       = r_ch_out;
  assign bus.valid_out    = r_valid_out;
  assign bus.frame_done   = r_frame_done;
  assign bus.err          = r_err;
  assign bus.params_ready = r_state == RUN;
endmodule

// File: tb/tb_conv_bn_relu_stream.sv
// tb_conv_bn_relu_stream: directed and random stimulus checked against an arithmetic BN+ReLU model
module tb_conv_bn_relu_stream;
  localparam int DW = 16, FB = 8, CH = 4, IMG = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  conv_bn_relu_stream_if #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH)) bus ();
  conv_bn_relu_stream #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .CHANNEL_NUM(CH), .IMAGE_SIZE(IMG)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int checks = 0, errors = 0, n_words = 0;
  logic [15:0] m_sc [CH], m_bi [CH], n_sc [CH], n_bi [CH];
  int e_px[$], e_ch[$], e_fd[$], g_px[$], g_ch[$], g_fd[$];
  always @(negedge clk)
    if (bus.valid_out === 1'b1) begin
      g_px.push_back(int'(bus.pxl_out));
      g_ch.push_back(int'(bus.ch_out));
      g_fd.push_back(int'(bus.frame_done));
    end
  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // y = clamp(floor(x*s/2^FB + 1/2) + b, 0, 2^15-1), all in real-number terms
  function automatic int refv(logic [15:0] x, logic [15:0] s, logic [15:0] b);
    longint d = longint'(1) << FB;
    longint t = longint'($signed(x)) * longint'($signed(s)) + d / 2;
    longint q = t >= 0 ? t / d : -((-t + d - 1) / d);
    longint v = q + longint'($signed(b));
    return v < 0 ? 0 : v > 32767 ? 32767 : int'(v);
  endfunction
  function automatic void model_push(logic [15:0] x);
    int c = n_words % CH;
    e_px.push_back(refv(x, m_sc[c], m_bi[c]));
    e_ch.push_back(c);
    e_fd.push_back(int'(n_words % (CH * IMG) == CH * IMG - 1));
    n_words++;
  endfunction
  function automatic void clear_q();
    e_px.delete(); e_ch.delete(); e_fd.delete();
    g_px.delete(); g_ch.delete(); g_fd.delete();
    n_words = 0;
  endfunction
  task automatic set_all(logic [15:0] s, logic [15:0] b);
    for (int c = 0; c < CH; c++) begin n_sc[c] = s; n_bi[c] = b; end
  endtask
  task automatic load_params();
    for (int i = 0; i < 2 * CH; i++) begin
      bus.valid_param_in = 1'b1;
      bus.param_in = (i % 2) ? n_bi[i/2] : n_sc[i/2];
      if (i == 2 * CH - 1) chk("ready_before_last", bus.params_ready, 0);
      @(negedge clk);
    end
    bus.valid_param_in = 1'b0;
    chk("ready_after_last", bus.params_ready, 1);
    m_sc = n_sc;
    m_bi = n_bi;
    n_words = 0;
  endtask
  task automatic drive_word(logic [15:0] x);
    bus.valid_in = 1'b1;
    bus.pxl_in = x;
    model_push(x);
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask
  task automatic drive_expect(string tag, logic [15:0] x, logic [15:0] e);
    drive_word(x);
    repeat (2) @(negedge clk);
    chk({tag, "_valid"}, bus.valid_out, 1);
    chk({tag, "_pxl"}, bus.pxl_out, e);
  endtask
  task automatic send_rand(int n, bit gaps);
    for (int i = 0; i < n; i++) begin
      drive_word(16'($urandom));
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask
  task automatic drain_check(string tag);
    repeat (6) @(negedge clk);
    chk({tag, "_count"}, g_px.size(), e_px.size());
    for (int i = 0; i < g_px.size() && i < e_px.size(); i++) begin
      chk($sformatf("%s_pxl%0d", tag, i), g_px[i], e_px[i]);
      chk($sformatf("%s_ch%0d", tag, i), g_ch[i], e_ch[i]);
      chk($sformatf("%s_fd%0d", tag, i), g_fd[i], e_fd[i]);
    end
    clear_q();
  endtask
  initial begin
    bus.valid_param_in = 1'b0; bus.param_in = '0; bus.valid_in = 1'b0; bus.pxl_in = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pxl", bus.pxl_out, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_ch", bus.ch_out, 0);
    chk("rst_ready", bus.params_ready, 0);
    chk("rst_fd", bus.frame_done, 0);
    chk("rst_err", bus.err, 0);
    reset = 1'b1;
    @(negedge clk);
    set_all(16'h0100, 16'h0080);
    load_params();
    bus.valid_in = 1'b1; bus.pxl_in = 16'h0200; model_push(16'h0200);
    @(negedge clk); bus.valid_in = 1'b0;
    chk("lat1_valid", bus.valid_out, 0);
    @(negedge clk);
    chk("lat2_valid", bus.valid_out, 0);
    @(negedge clk);
    chk("lat3_valid", bus.valid_out, 1);
    chk("lat3_pxl", bus.pxl_out, 16'h0280);
    chk("lat3_ch", bus.ch_out, 0);
    send_rand(7, 1);
    drain_check("f1");
    set_all(16'h0100, 16'h0000);
    load_params();
    drive_expect("relu", 16'hFE00, 16'h0000);
    send_rand(7, 1);
    drain_check("f2");
    set_all(16'h0200, 16'h0000);
    load_params();
    drive_expect("satpos", 16'h7F00, 16'h7FFF);
    drive_expect("satneg", 16'h8000, 16'h0000);
    send_rand(6, 1);
    drain_check("f3");
    set_all(16'h0080, 16'h0000);
    load_params();
    drive_expect("rnd1", 16'h0001, 16'h0001);
    drive_expect("rnd2", 16'h0002, 16'h0001);
    send_rand(6, 0);
    drain_check("f4");
    for (int c = 0; c < CH; c++) begin
      n_sc[c] = 16'($urandom_range(0, 1023)) - 16'd512;
      n_bi[c] = 16'($urandom);
    end
    load_params();
    send_rand(8, 0);
    drain_check("b2b");
    for (int c = 0; c < CH; c++) n_bi[c] = 16'($urandom_range(0, 16'h0FFF));
    load_params();
    send_rand(8, 1);
    drain_check("reload");
    chk("reload_err", bus.err, 0);
    send_rand(4, 0);
    bus.valid_param_in = 1'b1; bus.param_in = 16'h1234;
    @(negedge clk); bus.valid_param_in = 1'b0;
    chk("midparam_err", bus.err, 1);
    chk("midparam_ready", bus.params_ready, 1);
    send_rand(4, 0);
    drain_check("midparam");
    send_rand(3, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_pxl", bus.pxl_out, 0);
    chk("arst_valid", bus.valid_out, 0);
    chk("arst_ch", bus.ch_out, 0);
    chk("arst_ready", bus.params_ready, 0);
    chk("arst_fd", bus.frame_done, 0);
    chk("arst_err", bus.err, 0);
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    bus.valid_in = 1'b1; bus.pxl_in = 16'h0100;
    @(negedge clk); bus.valid_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("load_pix_outputs", g_px.size(), 0);
    chk("load_pix_err", bus.err, 1);
    chk("load_pix_ready", bus.params_ready, 0);
    load_params();
    send_rand(8, 1);
    drain_check("after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
